// File: rtl/sdio_data_rx.sv
// SDIO receive data path: deserialises 1/4-bit read blocks into 32-bit words with CRC16 check.
// Optional CRC16/stop-bit checking is built when SDIO_DATA_RX_CRC_EN is defined.
module sdio_data_rx #(
    parameter int unsigned BLOCK_SIZE_W = 10,
    parameter int unsigned BLOCK_NUM_W  = 8,
    parameter int unsigned TIMEOUT_W    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    quad_i,
    input  logic [BLOCK_SIZE_W-1:0] block_size_i,
    input  logic [BLOCK_NUM_W-1:0]  block_num_i,
    input  logic [TIMEOUT_W-1:0]    timeout_i,
    input  logic [3:0]              sddata_i,
    output logic [31:0]             data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o,
    output logic                    eot_o,
    output logic                    err_crc_o,
    output logic                    err_timeout_o,
    output logic                    err_overflow_o
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StWait = 3'd1;
    localparam logic [2:0] StData = 3'd2;
    localparam logic [2:0] StCrc  = 3'd3;
    localparam logic [2:0] StStop = 3'd4;

    logic [2:0]              state;
    logic                    quad_mode;
    logic [BLOCK_SIZE_W-1:0] block_size;
    logic [BLOCK_SIZE_W-1:0] byte_cnt;
    logic [BLOCK_NUM_W-1:0]  block_cnt;
    logic [TIMEOUT_W-1:0]    wait_cnt;
    logic [TIMEOUT_W-1:0]    wait_inc;
    logic [2:0]              bit_cnt;
    logic [7:0]              shift;
    logic [7:0]              shift_next;
    logic [1:0]              byte_idx;
    logic [23:0]             word_acc;
    logic [31:0]             word_next;
    logic [3:0]              crc_cnt;
    logic                    byte_done;
    logic                    last_byte;
    logic                    word_done;
    logic                    start_bit;

    always_comb begin
        shift_next = quad_mode ? {shift[3:0], sddata_i} : {shift[6:0], sddata_i[0]};
        byte_done  = quad_mode ? bit_cnt[0] : (bit_cnt == 3'd7);
        last_byte  = (byte_cnt == block_size);
        word_done  = byte_done && ((byte_idx == 2'd3) || last_byte);
        start_bit  = quad_mode ? (sddata_i == 4'h0) : !sddata_i[0];
        wait_inc   = wait_cnt + 1'b1;
        // Upper bytes of a partial word are zero because they are not yet written.
        word_next  = 32'h0;
        case (byte_idx)
            2'd0: word_next = {24'h0, shift_next};
            2'd1: word_next = {16'h0, shift_next, word_acc[7:0]};
            2'd2: word_next = {8'h0, shift_next, word_acc[15:0]};
            2'd3: word_next = {shift_next, word_acc[23:0]};
            default: word_next = 32'h0;
        endcase
    end

    assign busy_o = (state != StIdle);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= StIdle;
            quad_mode      <= 1'b0;
            block_size     <= '0;
            byte_cnt       <= '0;
            block_cnt      <= '0;
            wait_cnt       <= '0;
            bit_cnt        <= 3'd0;
            shift          <= 8'h0;
            byte_idx       <= 2'd0;
            word_acc       <= 24'h0;
            crc_cnt        <= 4'd0;
            data_o         <= 32'h0;
            valid_o        <= 1'b0;
            eot_o          <= 1'b0;
            err_timeout_o  <= 1'b0;
            err_overflow_o <= 1'b0;
        end else begin
            eot_o <= 1'b0;
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (start_i) begin
                        quad_mode      <= quad_i;
                        block_size     <= block_size_i;
                        block_cnt      <= block_num_i;
                        wait_cnt       <= '0;
                        err_timeout_o  <= 1'b0;
                        err_overflow_o <= 1'b0;
                        state          <= StWait;
                    end
                end
                StWait: begin
                    if (start_bit) begin
                        bit_cnt  <= 3'd0;
                        byte_cnt <= '0;
                        byte_idx <= 2'd0;
                        state    <= StData;
                    end else begin
                        wait_cnt <= wait_inc;
                        if ((timeout_i != '0) && (wait_inc == timeout_i)) begin
                            err_timeout_o <= 1'b1;
                            eot_o         <= 1'b1;
                            state         <= StIdle;
                        end
                    end
                end
                StData: begin
                    shift   <= shift_next;
                    bit_cnt <= byte_done ? 3'd0 : bit_cnt + 1'b1;
                    if (byte_done) begin
                        word_acc <= word_next[23:0];
                        byte_idx <= byte_idx + 1'b1;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (last_byte) begin
                            byte_idx <= 2'd0;
                            crc_cnt  <= 4'd0;
                            state    <= StCrc;
                        end
                    end
                    // The bus cannot stall, so a word arriving into a full register is lost.
                    if (word_done) begin
                        if (!valid_o || ready_i) begin
                            data_o  <= word_next;
                            valid_o <= 1'b1;
                        end else begin
                            err_overflow_o <= 1'b1;
                        end
                    end
                end
                StCrc: begin
                    crc_cnt <= crc_cnt + 1'b1;
                    if (crc_cnt == 4'd15) begin
                        state <= StStop;
                    end
                end
                StStop: begin
                    if (block_cnt != '0) begin
                        block_cnt <= block_cnt - 1'b1;
                        wait_cnt  <= '0;
                        state     <= StWait;
                    end else begin
                        eot_o <= 1'b1;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef SDIO_DATA_RX_CRC_EN
    logic [3:0][15:0] crc;
    logic             err_crc;
    logic             stop_ok;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    assign stop_ok = quad_mode ? (sddata_i == 4'hF) : sddata_i[0];

    // One CRC16 per data line, each covering only that line's own bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc     <= '0;
            err_crc <= 1'b0;
        end else begin
            case (state)
                StIdle: if (start_i) err_crc <= 1'b0;
                StWait: if (start_bit) crc <= '0;
                StData: begin
                    for (int i = 0; i < 4; i++) begin
                        if (quad_mode || (i == 0)) begin
                            crc[i] <= crc_step(crc[i], sddata_i[i]);
                        end
                    end
                end
                StCrc: begin
                    for (int i = 0; i < 4; i++) begin
                        if (quad_mode || (i == 0)) begin
                            if (sddata_i[i] != crc[i][15]) begin
                                err_crc <= 1'b1;
                            end
                            crc[i] <= {crc[i][14:0], 1'b0};
                        end
                    end
                end
                StStop: if (!stop_ok) err_crc <= 1'b1;
                default: ;
            endcase
        end
    end

    assign err_crc_o = err_crc;
`else
    assign err_crc_o = 1'b0;
`endif

endmodule

// File: tb/tb_sdio_data_rx.sv
// Self-checking bench for sdio_data_rx: bit-level SD driver, byte/word reference model.
module tb_sdio_data_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        quad;
    logic [9:0]  bsize;
    logic [7:0]  bnum;
    logic [15:0] tmo;
    logic [3:0]  sddata;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        eot;
    logic        err_crc;
    logic        err_to;
    logic        err_ov;

    int total = 0;
    int bad = 0;
    int eot_cnt = 0;
    int busy_gap = 0;
    logic xfer_active = 1'b0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  tx[$];
    logic [15:0] mcrc[4];
    logic        crc_on;

    always #5 clk = ~clk;

    sdio_data_rx #(
        .BLOCK_SIZE_W(10),
        .BLOCK_NUM_W (8),
        .TIMEOUT_W   (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .quad_i        (quad),
        .block_size_i  (bsize),
        .block_num_i   (bnum),
        .timeout_i     (tmo),
        .sddata_i      (sddata),
        .data_o        (data),
        .valid_o       (valid),
        .ready_i       (ready),
        .busy_o        (busy),
        .eot_o         (eot),
        .err_crc_o     (err_crc),
        .err_timeout_o (err_to),
        .err_overflow_o(err_ov)
    );

    always @(negedge clk) begin
        if (valid && ready) got_q.push_back(data);
        if (eot) eot_cnt++;
        if (xfer_active && !busy) busy_gap++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // CRC16-CCITT by polynomial long division, one message bit at a time.
    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        int v;
        v = int'(c) << 1;
        if (c[15] != b) v = v ^ 32'h1021;
        return v[15:0];
    endfunction

    task automatic drive(input logic [3:0] v);
        sddata = v;
        @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 ready = v;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic q, input logic [7:0] b);
        if (q) begin
            for (int k = 0; k < 4; k++) begin
                mcrc[k] = crc_bit(mcrc[k], b[4+k]);
                mcrc[k] = crc_bit(mcrc[k], b[k]);
            end
            drive(b[7:4]);
            drive(b[3:0]);
        end else begin
            for (int i = 7; i >= 0; i--) begin
                mcrc[0] = crc_bit(mcrc[0], b[i]);
                drive({3'($urandom), b[i]});
            end
        end
    endtask

    task automatic send_start_bit(input logic q);
        int idle;
        idle = $urandom_range(0, 3);
        for (int i = 0; i < idle; i++) drive(q ? 4'hF : {3'($urandom), 1'b1});
        for (int k = 0; k < 4; k++) mcrc[k] = 16'h0;
        drive(q ? 4'h0 : {3'($urandom), 1'b0});
    endtask

    task automatic send_block(input logic q, input int base, input int n, input int bad_line,
                              input logic last);
        logic [3:0] v;
        send_start_bit(q);
        for (int i = 0; i < n; i++) send_byte(q, tx[base+i]);
        for (int j = 15; j >= 0; j--) begin
            v = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                if (q || k == 0) v[k] = mcrc[k][j] ^ ((k == bad_line && j == 7) ? 1'b1 : 1'b0);
            end
            drive(v);
        end
        if (last) xfer_active = 1'b0;
        drive(q ? 4'hF : {3'($urandom), 1'b1});
    endtask

    // Starts at a negedge, returns at the negedge right after the final stop bit.
    task automatic run_transfer(input logic q, input int size, input int num,
                                input int bad_blk, input int bad_line);
        logic [31:0] w;
        int k;
        got_q.delete();
        exp_q.delete();
        for (int b = 0; b <= num; b++) begin
            w = 32'h0;
            k = 0;
            for (int i = 0; i <= size; i++) begin
                w = w | (32'(tx[b*(size+1)+i]) << (8 * k));
                k++;
                if (k == 4 || i == size) begin
                    exp_q.push_back(w);
                    w = 32'h0;
                    k = 0;
                end
            end
        end
        quad = q;
        bsize = 10'(size);
        bnum = 8'(num);
        start = 1'b1;
        sddata = 4'hF;
        @(negedge clk);
        start = 1'b0;
        xfer_active = 1'b1;
        for (int b = 0; b <= num; b++) begin
            send_block(q, b * (size + 1), size + 1, (b == bad_blk) ? bad_line : -1, b == num);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; quad = 1'b0; bsize = '0; bnum = '0; tmo = '0;
        sddata = 4'hF; ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", data); end
        total++; if ({valid, busy, eot} !== 3'b000) begin
            bad++; $display("FAIL reset_ctl got=%b exp=000", {valid, busy, eot}); end
        total++; if ({err_crc, err_to, err_ov} !== 3'b000) begin
            bad++; $display("FAIL reset_err got=%b exp=000", {err_crc, err_to, err_ov}); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_1bit;
        tx = '{8'hA5, 8'h01, 8'h02, 8'h03};
        eot_cnt = 0;
        run_transfer(1'b0, 3, 0, -1, -1);
        total++; if (eot !== 1'b1) begin bad++; $display("FAIL single_eot got=%b exp=1", eot); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
        @(negedge clk);
        total++; if (eot !== 1'b0) begin bad++; $display("FAIL single_eot_len got=%b exp=0", eot); end
        @(negedge clk);
        total++; if (eot_cnt != 1) begin bad++; $display("FAIL single_eot_cnt got=%0d exp=1", eot_cnt); end
        total++; if ({err_crc, err_to, err_ov} !== 3'b000) begin
            bad++; $display("FAIL single_err got=%b exp=000", {err_crc, err_to, err_ov}); end
        total++; if (got_q.size() != 1 || got_q[0] !== 32'h030201A5) begin
            bad++; $display("FAIL single_word got=%h n=%0d exp=030201a5",
                            got_q.size() > 0 ? got_q[0] : 32'hx, got_q.size()); end
    endtask

    task automatic test_quad_two_blocks;
        tx.delete();
        for (int i = 0; i < 16; i++) tx.push_back(8'(i));
        eot_cnt = 0;
        busy_gap = 0;
        run_transfer(1'b1, 7, 1, -1, -1);
        repeat (2) @(negedge clk);
        total++; if (busy_gap != 0) begin bad++; $display("FAIL quad_busy_gap got=%0d exp=0", busy_gap); end
        total++; if (eot_cnt != 1) begin bad++; $display("FAIL quad_eot_cnt got=%0d exp=1", eot_cnt); end
        total++; if (got_q.size() != 4) begin
            bad++; $display("FAIL quad_count got=%0d exp=4", got_q.size());
        end else begin
            total++; if (got_q[3] !== 32'h0F0E0D0C) begin
                bad++; $display("FAIL quad_last got=%h exp=0f0e0d0c", got_q[3]); end
            foreach (exp_q[i]) begin
                total++; if (got_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL quad_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_partial_word;
        tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_transfer(1'b0, 4, 0, -1, -1);
        repeat (2) @(negedge clk);
        total++; if (got_q.size() != 2) begin
            bad++; $display("FAIL partial_count got=%0d exp=2", got_q.size());
        end else begin
            total++; if (got_q[0] !== 32'h44332211) begin
                bad++; $display("FAIL partial_w0 got=%h exp=44332211", got_q[0]); end
            total++; if (got_q[1] !== 32'h00000055) begin
                bad++; $display("FAIL partial_w1 got=%h exp=00000055", got_q[1]); end
        end
    endtask

    task automatic test_random;
        int size;
        int num;
        logic q;
        for (int t = 0; t < 6; t++) begin
            q = 1'($urandom);
            size = $urandom_range(0, 13);
            num = $urandom_range(0, 2);
            tmo = 16'($urandom_range(0, 1) * 40);
            tx.delete();
            for (int i = 0; i < (size + 1) * (num + 1); i++) tx.push_back(8'($urandom));
            eot_cnt = 0;
            run_transfer(q, size, num, -1, -1);
            repeat (2) @(negedge clk);
            total++; if (eot_cnt != 1 || {err_crc, err_to, err_ov} !== 3'b000) begin
                bad++; $display("FAIL rand%0d_status got=eot%0d err%b exp=eot1 err000",
                                t, eot_cnt, {err_crc, err_to, err_ov}); end
            total++; if (got_q.size() != exp_q.size()) begin
                bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", t, got_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    total++; if (got_q[i] !== exp_q[i]) begin
                        bad++; $display("FAIL rand%0d_word%0d got=%h exp=%h", t, i, got_q[i], exp_q[i]);
                    end
                end
            end
        end
        tmo = 16'h0;
    endtask

    task automatic test_crc_error;
        tx.delete();
        for (int i = 0; i < 8; i++) tx.push_back(8'($urandom));
        eot_cnt = 0;
        run_transfer(1'b1, 7, 0, 0, 2);
        repeat (2) @(negedge clk);
        total++; if (err_crc !== crc_on) begin
            bad++; $display("FAIL crc_flag got=%b exp=%b", err_crc, crc_on); end
        total++; if (eot_cnt != 1) begin bad++; $display("FAIL crc_eot got=%0d exp=1", eot_cnt); end
        total++; if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
            bad++; $display("FAIL crc_words got_n=%0d exp_n=2", got_q.size()); end
        tx.delete();
        for (int i = 0; i < 4; i++) tx.push_back(8'($urandom));
        run_transfer(1'b0, 3, 0, -1, -1);
        total++; if (err_crc !== 1'b0) begin bad++; $display("FAIL crc_clear got=%b exp=0", err_crc); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int n;
        tmo = 16'd10;
        quad = 1'b1;
        sddata = 4'hF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (eot !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++; if (n != 10) begin bad++; $display("FAIL timeout_cycles got=%0d exp=10", n); end
        total++; if (err_to !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL timeout_flags got=to%b busy%b exp=to1 busy0", err_to, busy); end
        @(negedge clk);
        tmo = 16'd0;
        eot_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        total++; if (busy !== 1'b1 || eot_cnt != 0 || err_to !== 1'b0) begin
            bad++; $display("FAIL no_timeout got=busy%b eot%0d to%b exp=busy1 eot0 to0",
                            busy, eot_cnt, err_to); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overflow;
        set_ready(1'b0);
        tx.delete();
        for (int i = 0; i < 8; i++) tx.push_back(8'($urandom));
        run_transfer(1'b1, 7, 0, -1, -1);
        total++; if (valid !== 1'b1 || data !== exp_q[0]) begin
            bad++; $display("FAIL ovf_hold got=v%b %h exp=v1 %h", valid, data, exp_q[0]); end
        total++; if (err_ov !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", err_ov); end
        set_ready(1'b1);
        @(negedge clk);
        total++; if (valid !== 1'b0 || got_q.size() != 1) begin
            bad++; $display("FAIL ovf_drain got=v%b n=%0d exp=v0 n=1", valid, got_q.size()); end
    endtask

    task automatic test_reset_mid;
        set_ready(1'b0);
        quad = 1'b1;
        bsize = 10'd15;
        bnum = 8'd0;
        start = 1'b1;
        sddata = 4'hF;
        @(negedge clk);
        start = 1'b0;
        send_start_bit(1'b1);
        for (int i = 0; i < 6; i++) send_byte(1'b1, 8'(8'h10 + i));
        total++; if (valid !== 1'b1 || data !== 32'h13121110) begin
            bad++; $display("FAIL mid_pre got=v%b %h exp=v1 13121110", valid, data); end
        eot_cnt = 0;
        #2 rst = 1'b1;
        #1;
        total++; if ({valid, busy, eot, err_crc, err_to, err_ov} !== 6'b0 || data !== 32'h0) begin
            bad++; $display("FAIL mid_reset got=%b %h exp=000000 0",
                            {valid, busy, eot, err_crc, err_to, err_ov}, data); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) drive(4'h0);
        total++; if (eot_cnt != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_after got=eot%0d busy%b exp=eot0 busy0", eot_cnt, busy); end
        set_ready(1'b1);
    endtask

    initial begin
`ifdef SDIO_DATA_RX_CRC_EN
        crc_on = 1'b1;
`else
        crc_on = 1'b0;
`endif
        test_reset();
        test_single_1bit();
        test_quad_two_blocks();
        test_partial_word();
        test_random();
        test_crc_error();
        test_timeout();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdio_data_rx.md
Name: sdio_data_rx

Overview:
- Receive-side data path of the SDIO controller. Runs in the SDIO clock domain.
- Deserialises read data blocks from sddata_i in 1-bit or 4-bit mode and packs the bytes into 32-bit words.
- Pushes words into the RX dual-clock FIFO over a valid/ready stream, checks per-line CRC16, and reports end-of-transfer and errors to the transaction controller.

Parameters:
- BLOCK_SIZE_W, 10, width of block_size_i (bytes per block minus 1).
- BLOCK_NUM_W, 8, width of block_num_i (blocks per transfer minus 1).
- TIMEOUT_W, 16, width of timeout_i and the start-bit wait counter.

Ports:
- clk_i  in  1  SDIO clock; sddata_i is sampled on the rising edge.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  one-cycle pulse that begins a transfer; accepted only in IDLE.
- quad_i  in  1  1 = 4-bit bus, 0 = 1-bit bus (sddata_i[0] only); latched on start.
- block_size_i  in  BLOCK_SIZE_W  bytes per block minus 1; latched on start.
- block_num_i  in  BLOCK_NUM_W  blocks minus 1; latched on start.
- timeout_i  in  TIMEOUT_W  maximum cycles to wait for each start bit; 0 = no timeout.
- sddata_i  in  4  SD data lines.
- data_o  out  32  packed word.
- valid_o  out  1  data_o holds a valid word.
- ready_i  in  1  downstream FIFO accepts the word.
- busy_o  out  1  high whenever the state is not IDLE.
- eot_o  out  1  one-cycle end-of-transfer pulse.
- err_crc_o  out  1  sticky CRC or stop-bit error.
- err_timeout_o  out  1  sticky start-bit timeout.
- err_overflow_o  out  1  sticky: a word was dropped due to backpressure.

Behaviour:
- Reset: all outputs are 0, data_o = 0, state = IDLE. Reset asserted mid-transfer aborts immediately; no eot_o is produced.
- Accepting start_i in IDLE:
  - latches quad_i, block_size_i, block_num_i;
  - clears all three error flags;
  - goes to WAIT_START.
  - start_i in any other state is ignored.
- WAIT_START:
  - Start bit is sddata_i[0]==0 in 1-bit mode, or sddata_i==4'h0 in quad mode.
  - On the start bit: go to DATA and reset the CRC registers (one per used line) to 0.
  - Otherwise increment the wait counter. When the counter reaches timeout_i (timeout_i != 0): set err_timeout_o, pulse eot_o the next cycle, go to IDLE.
- DATA:
  - One bit per line per cycle, MSB first.
  - Quad mode: a nibble per cycle, sddata_i[3] is the MSB, 2 cycles per byte. 1-bit mode: 8 cycles per byte.
  - Bytes are packed little-endian: first byte of the block goes to data_o[7:0].
  - A word is emitted after the 4th byte, or after the last byte of the block. A partial last word has its upper bytes zero-padded. Words never span blocks.
  - After block_size_i+1 bytes, go to CRC.
- Output register:
  - One entry; valid_o rises the cycle after the final bit of the word is sampled.
  - The word is held until valid_o && ready_i.
  - If a new word completes while valid_o && !ready_i: the new word is dropped, err_overflow_o is set, and the transfer continues. The SD bus cannot be stalled.
- CRC:
  - 16 cycles; each used line is compared bit-serially against its CRC16-CCITT register (poly 0x1021, init 0).
  - Each CRC register is updated over that line's own data bits only.
  - Any mismatch sets err_crc_o.
- STOP:
  - One cycle; all used lines must be 1, otherwise err_crc_o is set.
  - Then, if the block counter is not zero: decrement it, reset the wait counter, go to WAIT_START.
  - Else: pulse eot_o next cycle, go to IDLE.
- Errors do not abort the transfer, except timeout.
- eot_o and valid_o are independent. A final word may still be pending in the output register when eot_o pulses.

Optional Feature:
- Macro: SDIO_DATA_RX_CRC_EN.
- Defined: CRC registers, CRC compare and stop-bit check are as above.
- Undefined:
  - no CRC registers are built;
  - the CRC and STOP cycles are still consumed with identical timing;
  - err_crc_o is tied to 0.

Test Plan:
- 1-bit mode, block_size=3, block_num=0, bytes A5 01 02 03 with valid CRC -> one word data_o=32'h030201A5, eot_o pulses 1 cycle after the stop bit, no errors.
- Quad mode, block_size=7, block_num=1, bytes 00..0F with valid CRCs -> 4 words: 03020100, 07060504, 0B0A0908, 0F0E0D0C; busy_o stays high between blocks; one eot_o.
- block_size=4, 1-bit, bytes 11 22 33 44 55 -> words 44332211, then 00000055.
- Flip one CRC bit on line 2 (quad) -> err_crc_o=1 after CRC phase, eot_o still pulses, data words still delivered; next start_i clears err_crc_o.
- timeout_i=10, sddata_i held 4'hF -> err_timeout_o=1 and eot_o after 10 wait cycles, busy_o=0; with timeout_i=0, waits indefinitely.
- ready_i=0 through 2 consecutive words -> first word held, second dropped, err_overflow_o=1. Separately, assert rst_i mid-DATA -> all outputs 0 asynchronously, no eot_o.
